axi_tmr_addr_voter: RTL and testbench

AXI_TMR_ADDR_VOTER -- requirements
Module: axi_tmr_addr_voter

---
 rtl/axi_tmr_addr_voter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_axi_tmr_addr_voter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tmr_addr_voter.sv
// Address-channel front end that decodes each command on three replica lanes,
// majority-votes the {hit,select} word and forwards it or answers with a decode error.
module axi_tmr_addr_voter #(
    parameter int M_COUNT = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH = 8,
    parameter logic [M_COUNT*ADDR_WIDTH-1:0] M_BASE_ADDR = '0,
    parameter logic [M_COUNT*32-1:0] M_ADDR_WIDTH = {M_COUNT{32'd24}},
    parameter logic [M_COUNT-1:0] M_SECURE = {M_COUNT{1'b0}},
    parameter int S_ACCEPT = 16,
    parameter int FAULT_THRESH = 3,
    parameter int CNT_W = 4,
    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_aid,
    input  logic [ADDR_WIDTH-1:0] s_axi_aaddr,
    input  logic [2:0]            s_axi_aprot,
    input  logic                  s_axi_avalid,
    output logic                  s_axi_aready,
    output logic [ID_WIDTH-1:0]   m_axi_aid,
    output logic [ADDR_WIDTH-1:0] m_axi_aaddr,
    output logic [2:0]            m_axi_aprot,
    output logic [SEL_W-1:0]      m_select,
    output logic                  m_axi_avalid,
    input  logic                  m_axi_aready,
    output logic                  m_rc_valid,
    output logic                  m_rc_decerr,
    input  logic                  m_rc_ready,
    input  logic                  s_cpl_valid,
    input  logic [2:0]            inj_lane,
    input  logic                  fault_clr,
    output logic [2:0]            fault_sticky,
    output logic [2:0]            lane_failed,
    output logic [3*CNT_W-1:0]    fault_cnt,
    output logic                  degraded,
    output logic                  uncorr
);

    localparam int OUT_W = $clog2(S_ACCEPT + 1);
    localparam logic USE_DEFAULT_BASE = (M_BASE_ADDR == '0);
    localparam logic [CNT_W-1:0] THRESH_C = FAULT_THRESH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, VOTE, ISSUE, DECERR} state_t;

    state_t r_state;
    state_t w_nextState;

    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_prot;
    logic [SEL_W-1:0]      r_select;
    logic [SEL_W:0]        r_laneWord [3];
    logic [OUT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_faultCnt [3];
    logic [2:0]            r_faultSticky;
    logic [2:0]            r_laneFailed;

    logic                  w_canAccept;
    logic                  w_accept;
    logic [SEL_W:0]        w_decoded;
    logic [2:0]            w_active;
    logic [1:0]            w_activeCnt;
    logic                  w_majValid;
    logic [SEL_W:0]        w_majWord;
    logic [2:0]            w_laneFault;
    logic [CNT_W-1:0]      w_cntNext [3];
    logic                  w_inc;
    logic                  w_dec;

    // Lowest-index region containing the address wins; a secure-only region
    // rejects non-secure accesses instead of falling through to the next master.
    function automatic logic [SEL_W:0] decode(input logic [ADDR_WIDTH-1:0] addr,
                                              input logic [2:0] prot);
        logic                  hit;
        logic                  found;
        logic [SEL_W-1:0]      sel;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] mask;
        int                    w;
        hit   = 1'b0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            w    = int'(M_ADDR_WIDTH[i*32 +: 32]);
            mask = {ADDR_WIDTH{1'b1}} << w;
            base = USE_DEFAULT_BASE ? (ADDR_WIDTH'(i) << w) : M_BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (!found && ((addr & mask) == (base & mask))) begin
                found = 1'b1;
                sel   = SEL_W'(i);
                hit   = !(M_SECURE[i] && prot[1]);
            end
        end
        return {hit, sel};
    endfunction

    assign w_decoded   = decode(s_axi_aaddr, s_axi_aprot);
    assign w_canAccept = (r_outstanding < OUT_W'(S_ACCEPT));
    assign w_accept    = (r_state == IDLE) && s_axi_avalid && w_canAccept;
    assign w_active    = ~r_laneFailed;
    assign w_activeCnt = {1'b0, w_active[0]} + {1'b0, w_active[1]} + {1'b0, w_active[2]};
    assign degraded    = (w_activeCnt <= 2'd1);

    always_comb begin
        w_majValid = 1'b0;
        w_majWord  = r_laneWord[0];
        case (w_active)
            3'b111: begin
                if ((r_laneWord[0] == r_laneWord[1]) || (r_laneWord[0] == r_laneWord[2])) begin
                    w_majValid = 1'b1;
                    w_majWord  = r_laneWord[0];
                end else if (r_laneWord[1] == r_laneWord[2]) begin
                    w_majValid = 1'b1;
                    w_majWord  = r_laneWord[1];
                end
            end
            3'b011: begin
                w_majValid = (r_laneWord[0] == r_laneWord[1]);
                w_majWord  = r_laneWord[0];
            end
            3'b101: begin
                w_majValid = (r_laneWord[0] == r_laneWord[2]);
                w_majWord  = r_laneWord[0];
            end
            3'b110: begin
                w_majValid = (r_laneWord[1] == r_laneWord[2]);
                w_majWord  = r_laneWord[1];
            end
            3'b001: begin
                w_majValid = 1'b1;
                w_majWord  = r_laneWord[0];
            end
            3'b010: begin
                w_majValid = 1'b1;
                w_majWord  = r_laneWord[1];
            end
            3'b100: begin
                w_majValid = 1'b1;
                w_majWord  = r_laneWord[2];
            end
            default: begin
                w_majValid = 1'b0;
                w_majWord  = r_laneWord[0];
            end
        endcase
    end

    // Only lanes still voting can be blamed, and only when a majority exists.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_laneFault[k] = (r_state == VOTE) && w_majValid && w_active[k] &&
                             (r_laneWord[k] != w_majWord);
            w_cntNext[k]   = (r_faultCnt[k] == CNT_MAX) ? r_faultCnt[k] : r_faultCnt[k] + CNT_W'(1);
            fault_cnt[k*CNT_W +: CNT_W] = r_faultCnt[k];
        end
    end

    assign fault_sticky = r_faultSticky;
    assign lane_failed  = r_laneFailed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        s_axi_aready = 1'b0;
        m_axi_avalid = 1'b0;
        m_rc_valid   = 1'b0;
        m_rc_decerr  = 1'b0;
        uncorr       = 1'b0;
        case (r_state)
            IDLE: begin
                s_axi_aready = w_canAccept;
                if (s_axi_avalid && w_canAccept) begin
                    w_nextState = VOTE;
                end
            end
            VOTE: begin
                if (!w_majValid) begin
                    uncorr      = 1'b1;
                    w_nextState = DECERR;
                end else if (w_majWord[SEL_W]) begin
                    w_nextState = ISSUE;
                end else begin
                    w_nextState = DECERR;
                end
            end
            ISSUE: begin
                m_axi_avalid = 1'b1;
                if (m_axi_aready) begin
                    w_nextState = IDLE;
                end
            end
            DECERR: begin
                m_rc_valid  = 1'b1;
                m_rc_decerr = 1'b1;
                if (m_rc_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Replica k sees inj_lane[k] as a flipped select LSB, emulating an upset in that lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_prot   <= '0;
            r_select <= '0;
            for (int k = 0; k < 3; k++) begin
                r_laneWord[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_id   <= s_axi_aid;
                r_addr <= s_axi_aaddr;
                r_prot <= s_axi_aprot;
                for (int k = 0; k < 3; k++) begin
                    r_laneWord[k] <= w_decoded ^ {{SEL_W{1'b0}}, inj_lane[k]};
                end
            end
            if ((r_state == VOTE) && w_majValid) begin
                r_select <= w_majWord[SEL_W-1:0];
            end
        end
    end

    assign m_axi_aid   = r_id;
    assign m_axi_aaddr = r_addr;
    assign m_axi_aprot = r_prot;
    assign m_select    = r_select;

    assign w_inc = (r_state == ISSUE) && m_axi_aready;
    assign w_dec = s_cpl_valid && (r_outstanding != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else if (w_inc && !w_dec) begin
            r_outstanding <= r_outstanding + OUT_W'(1);
        end else if (w_dec && !w_inc) begin
            r_outstanding <= r_outstanding - OUT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_faultSticky <= '0;
            r_laneFailed  <= '0;
            for (int k = 0; k < 3; k++) begin
                r_faultCnt[k] <= '0;
            end
        end else if (fault_clr) begin
            r_faultSticky <= '0;
            r_laneFailed  <= '0;
            for (int k = 0; k < 3; k++) begin
                r_faultCnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_laneFault[k]) begin
                    r_faultCnt[k]    <= w_cntNext[k];
                    r_faultSticky[k] <= 1'b1;
                    if (w_cntNext[k] >= THRESH_C) begin
                        r_laneFailed[k] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_tmr_addr_voter.sv
// Directed bench for axi_tmr_addr_voter: decode, voting, fault tracking,
// decode errors, outstanding limit and reset behaviour.
module tb_axi_tmr_addr_voter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axi_aid = '0;
    logic [31:0] s_axi_aaddr = '0;
    logic [2:0]  s_axi_aprot = '0;
    logic        s_axi_avalid = 1'b0;
    logic        s_axi_aready;
    logic [7:0]  m_axi_aid;
    logic [31:0] m_axi_aaddr;
    logic [2:0]  m_axi_aprot;
    logic [1:0]  m_select;
    logic        m_axi_avalid;
    logic        m_axi_aready = 1'b0;
    logic        m_rc_valid;
    logic        m_rc_decerr;
    logic        m_rc_ready = 1'b0;
    logic        s_cpl_valid = 1'b0;
    logic [2:0]  inj_lane = '0;
    logic        fault_clr = 1'b0;
    logic [2:0]  fault_sticky;
    logic [2:0]  lane_failed;
    logic [11:0] fault_cnt;
    logic        degraded;
    logic        uncorr;

    int          errorCount = 0;
    int          checkCount = 0;
    logic [7:0]  nextId = 8'h00;

    axi_tmr_addr_voter dut (
        .clk(clk), .rst(rst),
        .s_axi_aid(s_axi_aid), .s_axi_aaddr(s_axi_aaddr), .s_axi_aprot(s_axi_aprot),
        .s_axi_avalid(s_axi_avalid), .s_axi_aready(s_axi_aready),
        .m_axi_aid(m_axi_aid), .m_axi_aaddr(m_axi_aaddr), .m_axi_aprot(m_axi_aprot),
        .m_select(m_select), .m_axi_avalid(m_axi_avalid), .m_axi_aready(m_axi_aready),
        .m_rc_valid(m_rc_valid), .m_rc_decerr(m_rc_decerr), .m_rc_ready(m_rc_ready),
        .s_cpl_valid(s_cpl_valid), .inj_lane(inj_lane), .fault_clr(fault_clr),
        .fault_sticky(fault_sticky), .lane_failed(lane_failed), .fault_cnt(fault_cnt),
        .degraded(degraded), .uncorr(uncorr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one command, waits (bounded) for acceptance, returns in the VOTE cycle.
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] inj);
        int n = 0;
        s_axi_aid    = nextId;
        s_axi_aaddr  = addr;
        s_axi_aprot  = 3'b000;
        inj_lane     = inj;
        s_axi_avalid = 1'b1;
        while (!s_axi_aready && n < 40) begin
            step();
            n++;
        end
        checkOutput("acceptReady", s_axi_aready, 1'b1);
        step();
        s_axi_avalid = 1'b0;
        inj_lane     = 3'b000;
        nextId++;
    endtask

    task automatic issueHandshake(input logic cpl);
        m_axi_aready = 1'b1;
        s_cpl_valid  = cpl;
        step();
        m_axi_aready = 1'b0;
        s_cpl_valid  = 1'b0;
    endtask

    task automatic decerrHandshake();
        m_rc_ready = 1'b1;
        step();
        m_rc_ready = 1'b0;
    endtask

    task automatic runIssue(input logic [31:0] addr);
        applyStimulus(addr, 3'b000);
        step();
        checkOutput("fillValid", m_axi_avalid, 1'b1);
        issueHandshake(1'b0);
    endtask

    initial begin
        step();
        step();
        checkOutput("rstAvalid", m_axi_avalid, 1'b0);
        checkOutput("rstRcValid", m_rc_valid, 1'b0);
        checkOutput("rstSelect", m_select, 2'd0);
        checkOutput("rstUncorr", uncorr, 1'b0);
        checkOutput("rstDegraded", degraded, 1'b0);
        checkOutput("rstFaultCnt", fault_cnt, 12'h000);
        checkOutput("rstFailed", lane_failed, 3'b000);
        rst = 1'b0;
        step();
        checkOutput("idleReady", s_axi_aready, 1'b1);

        // Clean decode to master 2 with exact two-cycle latency.
        applyStimulus(32'h0200_1000, 3'b000);
        checkOutput("voteNoValid", m_axi_avalid, 1'b0);
        checkOutput("voteUncorr", uncorr, 1'b0);
        step();
        checkOutput("issueValid", m_axi_avalid, 1'b1);
        checkOutput("issueSelect", m_select, 2'd2);
        checkOutput("issueAddr", m_axi_aaddr, 32'h0200_1000);
        checkOutput("issueId", m_axi_aid, nextId - 8'd1);
        checkOutput("cleanSticky", fault_sticky, 3'b000);
        issueHandshake(1'b0);
        checkOutput("backIdle", m_axi_avalid, 1'b0);

        // Single upset on lane 1 is outvoted and recorded.
        applyStimulus(32'h0100_0000, 3'b010);
        checkOutput("corrUncorr", uncorr, 1'b0);
        step();
        checkOutput("corrSelect", m_select, 2'd1);
        checkOutput("corrCnt", fault_cnt, 12'h010);
        checkOutput("corrSticky", fault_sticky, 3'b010);
        issueHandshake(1'b0);

        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        checkOutput("clrCnt", fault_cnt, 12'h000);
        checkOutput("clrSticky", fault_sticky, 3'b000);

        // Clear in the same cycle as a lane fault wins.
        applyStimulus(32'h0100_0000, 3'b010);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        checkOutput("clrPrioCnt", fault_cnt, 12'h000);
        checkOutput("clrPrioSticky", fault_sticky, 3'b000);
        checkOutput("clrPrioSelect", m_select, 2'd1);
        issueHandshake(1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h0100_0000, 3'b010);
            step();
            checkOutput("threshSelect", m_select, 2'd1);
            issueHandshake(1'b0);
        end
        checkOutput("threshFailed", lane_failed, 3'b010);
        checkOutput("threshCnt", fault_cnt, 12'h030);
        checkOutput("threshDegraded", degraded, 1'b0);

        // Failed lane is masked: its disagreement is neither voted nor counted.
        applyStimulus(32'h0100_0000, 3'b010);
        checkOutput("maskUncorr", uncorr, 1'b0);
        step();
        checkOutput("maskValid", m_axi_avalid, 1'b1);
        checkOutput("maskSelect", m_select, 2'd1);
        checkOutput("maskCnt", fault_cnt, 12'h030);
        issueHandshake(1'b0);

        // Two remaining lanes disagree: uncorrectable.
        applyStimulus(32'h0100_0000, 3'b001);
        checkOutput("uncorrPulse", uncorr, 1'b1);
        step();
        checkOutput("uncorrOnce", uncorr, 1'b0);
        checkOutput("uncorrRcValid", m_rc_valid, 1'b1);
        checkOutput("uncorrDecerr", m_rc_decerr, 1'b1);
        checkOutput("uncorrNoIssue", m_axi_avalid, 1'b0);
        checkOutput("uncorrCnt", fault_cnt, 12'h030);
        decerrHandshake();
        checkOutput("uncorrDone", m_rc_valid, 1'b0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        checkOutput("clr2Failed", lane_failed, 3'b000);
        checkOutput("clr2Cnt", fault_cnt, 12'h000);
        checkOutput("clr2Sticky", fault_sticky, 3'b000);

        // Unmapped address: decode error held until accepted.
        applyStimulus(32'h0500_0000, 3'b000);
        checkOutput("decUncorr", uncorr, 1'b0);
        step();
        checkOutput("decRcValid", m_rc_valid, 1'b1);
        checkOutput("decDecerr", m_rc_decerr, 1'b1);
        checkOutput("decNoIssue", m_axi_avalid, 1'b0);
        step();
        checkOutput("decHold", m_rc_valid, 1'b1);
        decerrHandshake();
        checkOutput("decDone", m_rc_valid, 1'b0);

        // Reset while a command waits in ISSUE.
        applyStimulus(32'h0300_0000, 3'b010);
        step();
        checkOutput("preRstValid", m_axi_avalid, 1'b1);
        checkOutput("preRstSelect", m_select, 2'd3);
        checkOutput("preRstCnt", fault_cnt, 12'h010);
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", m_axi_avalid, 1'b0);
        checkOutput("midRstSelect", m_select, 2'd0);
        checkOutput("midRstCnt", fault_cnt, 12'h000);
        checkOutput("midRstSticky", fault_sticky, 3'b000);
        step();
        rst = 1'b0;
        step();
        checkOutput("postRstReady", s_axi_aready, 1'b1);
        checkOutput("postRstValid", m_axi_avalid, 1'b0);

        // Completion at zero outstanding must be ignored.
        s_cpl_valid = 1'b1;
        step();
        s_cpl_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            runIssue(32'h0000_0100 * i);
        end
        checkOutput("fifteenReady", s_axi_aready, 1'b1);
        runIssue(32'h0000_2000);
        checkOutput("fullReady", s_axi_aready, 1'b0);

        s_axi_aaddr  = 32'h0000_3000;
        s_axi_avalid = 1'b1;
        s_cpl_valid  = 1'b1;
        checkOutput("fullBlocks", s_axi_aready, 1'b0);
        step();
        s_cpl_valid  = 1'b0;
        s_axi_avalid = 1'b0;
        checkOutput("cplReopens", s_axi_aready, 1'b1);

        applyStimulus(32'h0000_4000, 3'b000);
        step();
        issueHandshake(1'b1);
        checkOutput("incDecHold", s_axi_aready, 1'b1);
        runIssue(32'h0000_5000);
        checkOutput("refull", s_axi_aready, 1'b0);
        s_cpl_valid = 1'b1;
        step();
        s_cpl_valid = 1'b0;
        checkOutput("finalReady", s_axi_aready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
